vga_pattern_pipeline: RTL and testbench

- Downstream consumer of the video sync generator. Takes raw timing (hsync, vsync, hpos, vpos, visible) and produces registered, board-ready VGA pins: active-low syncs and 3-bit R/G/B.
- Selects one of four test patterns, including an animated one driven by a frame counter.
- Pattern changes requested from outside are deferred to the next frame boundary, so no frame is torn.

---
 rtl/vga_pkg.sv | 13 +
 rtl/vga_frame_ctrl.sv | 49 ++++
 rtl/vga_pattern_pipeline.sv | 140 ++++++++++++++
 tb/tb_vga_pattern_pipeline.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA pattern pipeline: pattern mode encodings and default geometry.
// The optional 1-pixel white border is enabled by defining VGA_BORDER_EN.
package vga_pkg;
  localparam int COLOR_BITS_DEF = 3;
  localparam int H_ACTIVE_DEF   = 640;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int FRAME_BITS_DEF = 8;

  localparam logic [1:0] MODE_GRID   = 2'd0;
  localparam logic [1:0] MODE_BARS   = 2'd1;
  localparam logic [1:0] MODE_SCROLL = 2'd2;
  localparam logic [1:0] MODE_SOLID  = 2'd3;
endpackage

// File: rtl/vga_frame_ctrl.sv
// Frame controller: vsync rising-edge detect, completed-frame counter and
// pending/active pattern mode registers (mode changes land only on frame start).
module vga_frame_ctrl
  import vga_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_vsync,
  input  logic                  i_mode_we,
  input  logic [1:0]            i_mode,
  output logic [1:0]            o_active_mode,
  output logic [FRAME_BITS-1:0] o_frame_count
);
  logic                  vsync_prev_q, vsync_prev_d;
  logic [1:0]            pending_q, pending_d;
  logic [1:0]            active_q, active_d;
  logic [FRAME_BITS-1:0] frame_count_q, frame_count_d;
  logic                  frame_start;

  always_comb begin
    frame_start   = i_vsync & ~vsync_prev_q;
    vsync_prev_d  = i_vsync;
    pending_d     = i_mode_we ? i_mode : pending_q;
    // Active takes the pending value held before this cycle, so a write coinciding
    // with frame start is deferred to the following frame.
    active_d      = frame_start ? pending_q : active_q;
    frame_count_d = frame_start ? frame_count_q + FRAME_BITS'(1) : frame_count_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vsync_prev_q  <= 1'b0;
      pending_q     <= MODE_GRID;
      active_q      <= MODE_GRID;
      frame_count_q <= '0;
    end else begin
      vsync_prev_q  <= vsync_prev_d;
      pending_q     <= pending_d;
      active_q      <= active_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign o_active_mode = active_q;
  assign o_frame_count = frame_count_q;
endmodule

// File: rtl/vga_pattern_pipeline.sv
// Two-stage VGA output pipeline: registers raw timing, renders one of four test patterns,
// and drives active-low syncs plus RGB with a fixed 2-cycle latency. Border: VGA_BORDER_EN.
module vga_pattern_pipeline
  import vga_pkg::*;
#(
  parameter int COLOR_BITS = COLOR_BITS_DEF,
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int FRAME_BITS = FRAME_BITS_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_hsync,
  input  logic                  i_vsync,
  input  logic [9:0]            i_hpos,
  input  logic [9:0]            i_vpos,
  input  logic                  i_visible,
  input  logic                  i_mode_we,
  input  logic [1:0]            i_mode,
  output logic                  o_hsync_n,
  output logic                  o_vsync_n,
  output logic [COLOR_BITS-1:0] o_red,
  output logic [COLOR_BITS-1:0] o_grn,
  output logic [COLOR_BITS-1:0] o_blu,
  output logic [FRAME_BITS-1:0] o_frame_count,
  output logic [1:0]            o_mode
);
  // Stage 1: timing registers (mode and frame count live in the frame controller).
  logic       hsync_s1_q, vsync_s1_q, visible_s1_q;
  logic [9:0] hpos_s1_q, vpos_s1_q;
  logic [1:0]            mode_s1;
  logic [FRAME_BITS-1:0] frame_count_s1;

  // Stage 2: output pins.
  logic                  hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d;
  logic [COLOR_BITS-1:0] red_q, red_d, grn_q, grn_d, blu_q, blu_d;

  logic [9:0] sum;
  logic [2:0] bar;
  logic       unused_vpos_bits;

  vga_frame_ctrl #(.FRAME_BITS(FRAME_BITS)) u_frame_ctrl (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_vsync       (i_vsync),
    .i_mode_we     (i_mode_we),
    .i_mode        (i_mode),
    .o_active_mode (mode_s1),
    .o_frame_count (frame_count_s1)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      hsync_s1_q   <= 1'b0;
      vsync_s1_q   <= 1'b0;
      visible_s1_q <= 1'b0;
      hpos_s1_q    <= '0;
      vpos_s1_q    <= '0;
    end else begin
      hsync_s1_q   <= i_hsync;
      vsync_s1_q   <= i_vsync;
      visible_s1_q <= i_visible;
      hpos_s1_q    <= i_hpos;
      vpos_s1_q    <= i_vpos;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    red_d = '0;
    grn_d = '0;
    blu_d = '0;
    sum   = hpos_s1_q + 10'(frame_count_s1);
    bar   = hpos_s1_q[8:6];
    case (mode_s1)
      MODE_GRID: begin
        red_d = (hpos_s1_q[2:0] == 3'd0 || vpos_s1_q[2:0] == 3'd0) ? '1 : '0;
        grn_d = {COLOR_BITS{vpos_s1_q[4]}};
        blu_d = {COLOR_BITS{hpos_s1_q[4]}};
      end
      MODE_BARS: begin
        red_d = {COLOR_BITS{bar[0]}};
        grn_d = {COLOR_BITS{bar[1]}};
        blu_d = {COLOR_BITS{bar[2]}};
      end
      MODE_SCROLL: begin
        red_d = sum[3 +: COLOR_BITS];
        grn_d = vpos_s1_q[3 +: COLOR_BITS];
        blu_d = frame_count_s1[FRAME_BITS-COLOR_BITS +: COLOR_BITS];
      end
      default: begin
        red_d = '1;
        grn_d = '1;
        blu_d = '1;
      end
    endcase
`ifdef VGA_BORDER_EN
    if (hpos_s1_q == 10'(H_ACTIVE-1) || hpos_s1_q == 10'd0 ||
        vpos_s1_q == 10'(V_ACTIVE-1) || vpos_s1_q == 10'd0) begin
      red_d = '1;
      grn_d = '1;
      blu_d = '1;
    end
`endif
    if (!visible_s1_q) begin
      red_d = '0;
      grn_d = '0;
      blu_d = '0;
    end
    hsync_n_d = ~hsync_s1_q;
    vsync_n_d = ~vsync_s1_q;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
      red_q     <= '0;
      grn_q     <= '0;
      blu_q     <= '0;
    end else begin
      hsync_n_q <= hsync_n_d;
      vsync_n_q <= vsync_n_d;
      red_q     <= red_d;
      grn_q     <= grn_d;
      blu_q     <= blu_d;
    end
  end

  // High vpos bits only feed the border compare, which may be compiled out.
  assign unused_vpos_bits = ^{vpos_s1_q, sum};

  assign o_hsync_n     = hsync_n_q;
  assign o_vsync_n     = vsync_n_q;
  assign o_red         = red_q;
  assign o_grn         = grn_q;
  assign o_blu         = blu_q;
  assign o_frame_count = frame_count_s1;
  assign o_mode        = mode_s1;
endmodule

// File: tb/tb_vga_pattern_pipeline.sv
// Directed bench for vga_pattern_pipeline: reset, latency, patterns, mode deferral,
// frame counter wrap, blanking and the optional border (VGA_BORDER_EN).
module tb_vga_pattern_pipeline;
  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_hsync, i_vsync, i_visible, i_mode_we;
  logic [9:0] i_hpos, i_vpos;
  logic [1:0] i_mode;
  logic       o_hsync_n, o_vsync_n;
  logic [2:0] o_red, o_grn, o_blu;
  logic [7:0] o_frame_count;
  logic [1:0] o_mode;

  int n_checks = 0;
  int n_pass   = 0;

  vga_pattern_pipeline dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_hsync       (i_hsync),
    .i_vsync       (i_vsync),
    .i_hpos        (i_hpos),
    .i_vpos        (i_vpos),
    .i_visible     (i_visible),
    .i_mode_we     (i_mode_we),
    .i_mode        (i_mode),
    .o_hsync_n     (o_hsync_n),
    .o_vsync_n     (o_vsync_n),
    .o_red         (o_red),
    .o_grn         (o_grn),
    .o_blu         (o_blu),
    .o_frame_count (o_frame_count),
    .o_mode        (o_mode)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_rgb(input string tag, input logic [2:0] r, input logic [2:0] g,
                           input logic [2:0] b);
    check({tag, ".red"}, 16'(o_red), 16'(r));
    check({tag, ".grn"}, 16'(o_grn), 16'(g));
    check({tag, ".blu"}, 16'(o_blu), 16'(b));
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic write_mode(input logic [1:0] m);
    i_mode_we = 1'b1;
    i_mode    = m;
    tick(1);
    i_mode_we = 1'b0;
  endtask

  task automatic frame_pulse();
    i_vsync = 1'b1;
    tick(1);
    i_vsync = 1'b0;
    tick(1);
  endtask

  task automatic show_pixel(input logic [9:0] h, input logic [9:0] v, input logic vis);
    i_hpos    = h;
    i_vpos    = v;
    i_visible = vis;
    tick(2);
  endtask

  initial begin
    i_reset = 1'b1;
    i_hsync = 1'b0; i_vsync = 1'b0; i_visible = 1'b0;
    i_hpos  = '0;   i_vpos  = '0;   i_mode_we = 1'b0; i_mode = '0;
    #3;
    check("rst.hsync_n", 16'(o_hsync_n), 16'd1);
    check("rst.vsync_n", 16'(o_vsync_n), 16'd1);
    check_rgb("rst", 3'd0, 3'd0, 3'd0);
    check("rst.frame_count", 16'(o_frame_count), 16'd0);
    check("rst.mode", 16'(o_mode), 16'd0);
    tick(1);
    i_reset = 1'b0;
    tick(1);

    // Sync latency: exactly two cycles.
    i_hsync = 1'b1;
    tick(1);
    check("lat.hsync_n+1", 16'(o_hsync_n), 16'd1);
    tick(1);
    check("lat.hsync_n+2", 16'(o_hsync_n), 16'd0);
    i_hsync = 1'b0;
    tick(2);
    check("lat.hsync_n_release", 16'(o_hsync_n), 16'd1);

    // Grid pattern.
    i_hpos = 10'd16; i_vpos = 10'd0; i_visible = 1'b1;
    tick(1);
    check_rgb("grid.lat1", 3'd0, 3'd0, 3'd0);
    tick(1);
    check_rgb("grid.h16v0", 3'd7, 3'd0, 3'd7);
    show_pixel(10'd5, 10'd17, 1'b1);
    check_rgb("grid.h5v17", 3'd0, 3'd7, 3'd0);
    show_pixel(10'd3, 10'd3, 1'b1);
    check_rgb("grid.h3v3", 3'd0, 3'd0, 3'd0);

    // Mode write mid-frame is deferred to the next vsync rising edge.
    write_mode(2'd1);
    tick(3);
    check("defer.mode_before", 16'(o_mode), 16'd0);
    i_vsync = 1'b1;
    tick(1);
    check("defer.mode_after", 16'(o_mode), 16'd1);
    check("defer.frame_count", 16'(o_frame_count), 16'd1);
    check("defer.vsync_n+1", 16'(o_vsync_n), 16'd1);
    tick(1);
    check("defer.vsync_n+2", 16'(o_vsync_n), 16'd0);
    check("defer.no_second_edge", 16'(o_frame_count), 16'd1);
    i_vsync = 1'b0;
    tick(1);
    show_pixel(10'd320, 10'd50, 1'b1);
    check_rgb("bars.h320", 3'd7, 3'd0, 3'd7);

    // Last write wins; a write on the frame-start cycle waits one more frame.
    write_mode(2'd0);
    write_mode(2'd3);
    i_vsync = 1'b1; i_mode_we = 1'b1; i_mode = 2'd2;
    tick(1);
    i_mode_we = 1'b0;
    check("simul.mode_now", 16'(o_mode), 16'd3);
    check("simul.frame_count", 16'(o_frame_count), 16'd2);
    i_vsync = 1'b0;
    tick(1);
    frame_pulse();
    check("simul.mode_next", 16'(o_mode), 16'd2);
    check("simul.frame_count_next", 16'(o_frame_count), 16'd3);

    // Scroll pattern at frame_count = 10.
    for (int i = 0; i < 7; i++) frame_pulse();
    check("scroll.frame_count", 16'(o_frame_count), 16'd10);
    show_pixel(10'd1020, 10'd40, 1'b1);
    check_rgb("scroll.h1020", 3'd0, 3'd5, 3'd0);
    show_pixel(10'd100, 10'd40, 1'b1);
    check_rgb("scroll.h100", 3'd5, 3'd5, 3'd0);

    // Frame counter wrap.
    for (int i = 0; i < 245; i++) frame_pulse();
    check("wrap.at_255", 16'(o_frame_count), 16'd255);
    show_pixel(10'd0, 10'd8, 1'b1);
    check_rgb("scroll.fc255", 3'd7, 3'd1, 3'd7);
    frame_pulse();
    check("wrap.to_0", 16'(o_frame_count), 16'd0);

    // Bars at the right edge: border overrides when enabled.
    write_mode(2'd1);
    frame_pulse();
    check("bars.mode", 16'(o_mode), 16'd1);
    show_pixel(10'd639, 10'd100, 1'b1);
`ifdef VGA_BORDER_EN
    check_rgb("edge.h639", 3'd7, 3'd7, 3'd7);
`else
    check_rgb("edge.h639", 3'd7, 3'd0, 3'd0);
`endif
    show_pixel(10'd64, 10'd100, 1'b1);
    check_rgb("bars.h64", 3'd7, 3'd0, 3'd0);

    // Solid pattern and blanking.
    write_mode(2'd3);
    frame_pulse();
    check("solid.mode", 16'(o_mode), 16'd3);
    show_pixel(10'd200, 10'd200, 1'b1);
    check_rgb("solid.vis", 3'd7, 3'd7, 3'd7);
    show_pixel(10'd200, 10'd200, 1'b0);
    check_rgb("blank.solid", 3'd0, 3'd0, 3'd0);

    // Asynchronous reset mid-line blanks the outputs immediately.
    i_hsync = 1'b1;
    show_pixel(10'd200, 10'd200, 1'b1);
    check("pre_rst.hsync_n", 16'(o_hsync_n), 16'd0);
    #2;
    i_reset = 1'b1;
    #1;
    check("arst.hsync_n", 16'(o_hsync_n), 16'd1);
    check("arst.vsync_n", 16'(o_vsync_n), 16'd1);
    check_rgb("arst", 3'd0, 3'd0, 3'd0);
    check("arst.frame_count", 16'(o_frame_count), 16'd0);
    check("arst.mode", 16'(o_mode), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
